hazard_ctrl: RTL

- Consumer-side hazard and forwarding controller for the 5-stage MIPS pipeline (D/E/M/W).
- Each producing instruction's destination register (A3), Tnew and forwarding-source select (FWSrcSel) come from the per-stage decoder. This block carries them down E/M/W and compares them against the D-stage register reads (A1/A2) and their Tuse.
- Outputs stall/bubble control and per-operand forwarding mux selects for the D and E stages.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: consumer-side hazard / forwarding control for the D/E/M/W pipe.
// Carries each producer's destination, Tnew and forwarding source down E/M/W
// and compares them against the D-stage reads (stall + D forward selects) and
// the E-stage reads (E forward selects).
// Select encoding for all *_fwd_* outputs: 0 RF, 1 E, 2 M, 3 W.
// Optional: define HAZARD_STAT_EN to get a free-running stall-cycle counter on
// stall_cnt; otherwise stall_cnt is tied to zero.

// Per-operand compare slice: one instance per read port (rs, rt).
module hazard_opnd #(
  parameter int W_BYPASS = 1,
  parameter int TNEW_W   = 2
) (
  input  logic [4:0]        a_d,
  input  logic [TNEW_W-1:0] tuse_d,
  input  logic [4:0]        a_e,
  input  logic [4:0]        a3_e,
  input  logic [4:0]        a3_m,
  input  logic [4:0]        a3_w,
  input  logic [TNEW_W-1:0] tnew_e,
  input  logic [TNEW_W-1:0] tnew_m,
  input  logic [TNEW_W-1:0] tnew_w,
  output logic              stall,
  output logic [1:0]        dsel,
  output logic [1:0]        esel
);
  logic dhit_e, dhit_m, dhit_w, ehit_m, ehit_w, used;

  // $0 never matches, so an a3 of 0 acts as an empty slot
  assign dhit_e = (a_d != 5'd0) && (a_d == a3_e);
  assign dhit_m = (a_d != 5'd0) && (a_d == a3_m);
  assign dhit_w = (a_d != 5'd0) && (a_d == a3_w);
  assign ehit_m = (a_e != 5'd0) && (a_e == a3_m);
  assign ehit_w = (a_e != 5'd0) && (a_e == a3_w);
  assign used   = (tuse_d != '1);

  // Stall when a pending producer in E or M will not be ready by the time the
  // operand is consumed; W is always ready so never stalls.
  always_comb begin
    stall = used && ((dhit_e && (tnew_e > tuse_d)) || (dhit_m && (tnew_m > tuse_d)));
  end

  // D forward: the youngest matching producer wins; if it is not ready yet the
  // operand reads RF (older copies are stale) and the stall / later E forward
  // covers the hazard.
  always_comb begin
    dsel = 2'd0;
    if (dhit_e)      dsel = (tnew_e == '0) ? 2'd1 : 2'd0;
    else if (dhit_m) dsel = (tnew_m == '0) ? 2'd2 : 2'd0;
    else if (dhit_w) dsel = ((W_BYPASS != 0) && (tnew_w == '0)) ? 2'd3 : 2'd0;
  end

  // E forward: same youngest-match rule over M then W.
  always_comb begin
    esel = 2'd0;
    if (ehit_m)      esel = (tnew_m == '0) ? 2'd2 : 2'd0;
    else if (ehit_w) esel = ((W_BYPASS != 0) && (tnew_w == '0)) ? 2'd3 : 2'd0;
  end
endmodule

module hazard_ctrl #(
  parameter int W_BYPASS = 1,
  parameter int TNEW_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        d_a1,
  input  logic [4:0]        d_a2,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [2:0]        d_fwsrc,
  output logic              stall,
  output logic [1:0]        d_fwd_rs,
  output logic [1:0]        d_fwd_rt,
  output logic [1:0]        e_fwd_rs,
  output logic [1:0]        e_fwd_rt,
  output logic [2:0]        e_fwsrc,
  output logic [2:0]        m_fwsrc,
  output logic [2:0]        w_fwsrc,
  output logic [31:0]       stall_cnt
);
  localparam int NOPS = 2;  // index 0 = rs, 1 = rt

  logic [4:0]        a3_e, a3_m, a3_w, rs_e, rt_e;
  logic [TNEW_W-1:0] tnew_e, tnew_m, tnew_w;
  logic [2:0]        fwsrc_e, fwsrc_m, fwsrc_w;

  logic [NOPS-1:0][4:0]        d_a, e_a;
  logic [NOPS-1:0][TNEW_W-1:0] d_tuse;
  logic [NOPS-1:0]             op_stall;
  logic [NOPS-1:0][1:0]        dsel, esel;

  assign d_a    = {d_a2, d_a1};
  assign e_a    = {rt_e, rs_e};
  assign d_tuse = {d_tuse_rt, d_tuse_rs};

  function automatic logic [TNEW_W-1:0] tdec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    hazard_opnd #(.W_BYPASS(W_BYPASS), .TNEW_W(TNEW_W)) u_op (
      .a_d    (d_a[g]),
      .tuse_d (d_tuse[g]),
      .a_e    (e_a[g]),
      .a3_e   (a3_e),
      .a3_m   (a3_m),
      .a3_w   (a3_w),
      .tnew_e (tnew_e),
      .tnew_m (tnew_m),
      .tnew_w (tnew_w),
      .stall  (op_stall[g]),
      .dsel   (dsel[g]),
      .esel   (esel[g])
    );
  end

  assign stall    = |op_stall;
  // D selects are meaningless while the D instruction is being held
  assign d_fwd_rs = stall ? 2'd0 : dsel[0];
  assign d_fwd_rt = stall ? 2'd0 : dsel[1];
  assign e_fwd_rs = esel[0];
  assign e_fwd_rt = esel[1];
  assign e_fwsrc  = fwsrc_e;
  assign m_fwsrc  = fwsrc_m;
  assign w_fwsrc  = fwsrc_w;

  // Stage chain: E takes D (or a bubble on stall), M/W always advance with Tnew
  // counting down toward ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_e <= '0; tnew_e <= '0; fwsrc_e <= '0; rs_e <= '0; rt_e <= '0;
      a3_m <= '0; tnew_m <= '0; fwsrc_m <= '0;
      a3_w <= '0; tnew_w <= '0; fwsrc_w <= '0;
    end else begin
      if (stall) begin
        a3_e <= '0; tnew_e <= '0; fwsrc_e <= '0; rs_e <= '0; rt_e <= '0;
      end else begin
        a3_e <= d_a3; tnew_e <= d_tnew; fwsrc_e <= d_fwsrc; rs_e <= d_a1; rt_e <= d_a2;
      end
      a3_m <= a3_e; tnew_m <= tdec(tnew_e); fwsrc_m <= fwsrc_e;
      a3_w <= a3_m; tnew_w <= tdec(tnew_m); fwsrc_w <= fwsrc_m;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] cnt;
  // Count cycles spent stalled; wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (stall) cnt <= cnt + 32'd1;
  end
  assign stall_cnt = cnt;
`else
  assign stall_cnt = 32'd0;
`endif
endmodule
